rob_nway: RTL and testbench
===========================

Name: rob_nway

Overview:
Parametrised N-way reorder buffer. It holds in-order instruction state between dispatch and retire, with a configurable number of entries and a configurable superscalar width. It accepts up to WAY dispatches, WAY completions and WAY retires per cycle, and supports single-cycle rollback to a mispredicted branch. It adds an occupancy counter, partial (packed) dispatch and a sticky halt state, and feeds the arch map, free list, store queue and load queue at retire.

Parameters:
NUM_ROB, 32, entry count; power of two, at least 4; PTR_W = $clog2(NUM_ROB).
WAY, 2, dispatch/complete/retire width; 1 <= WAY <= NUM_ROB/2.
PREG_W, 6, physical register index width.
AREG_W, 5, architectural register index width.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
en  in  1  global stall; when 0, no state changes; outputs still driven combinationally
dispatch_valid  in  WAY  per-slot dispatch request; must be packed (slot k set implies slot k-1 set)
dispatch_pkt  in  WAY x ROB_PKT_t  {T_idx, Told_idx, dest_idx, halt, wr_mem, rd_mem}
dispatch_ready  out  1  at least WAY free entries, not halted, no rollback this cycle
dispatch_idx  out  WAY x PTR_W  entry index assigned to each slot: tail+k
complete_en  in  WAY  per-port completion strobe
complete_idx  in  WAY x PTR_W  entry completing
retire_allow  in  WAY  per-slot permission from the store queue
rollback_en  in  1  mispredict recovery request
rollback_idx  in  PTR_W  entry of the mispredicted branch; this entry survives
retire_en  out  WAY  slot k retires entry head+k this cycle
retire_pkt  out  WAY x ROB_PKT_t  contents of entry head+k
halted  out  1  a halt has retired; sticky until reset
count  out  PTR_W+1  valid entries, 0..NUM_ROB

Behaviour:
- Storage: circular array with head, tail and count registers. All pointer arithmetic is mod NUM_ROB by natural PTR_W wrap.
- Reset: all valid/complete bits 0, head=tail=0, count=0, state RUN. Consequently retire_en=0, halted=0, dispatch_ready=1 (0 if rollback_en is high), dispatch_idx[k]=k.
- State machine: RUN -> HALTED on any retire of an entry with halt=1. HALTED holds until reset; in HALTED, retire_en=0 and dispatch_ready=0.
- Dispatch: accepted when dispatch_ready & en. Slot k writes entry tail+k with valid=1, complete=0 and the packet. tail += popcount(dispatch_valid). Unpacked dispatch_valid is illegal and is asserted against in the bench. dispatch_valid asserted while dispatch_ready=0 is ignored.
- dispatch_ready uses the registered count only (NUM_ROB - count >= WAY). It does not account for same-cycle retires.
- Complete: sets the complete bit of complete_idx[k] only if that entry is valid. Completions to invalid or squashed entries are dropped. Duplicate indices are harmless.
- Retire: retire_en[k] is the AND of:
  - entry head+k valid & complete
  - retire_allow[k]
  - retire_en[k-1]
  - no halt among slots 0..k-1 (a halt retires alone as the youngest retiring slot)
  - !rollback_en
  - state==RUN
  On en: head += popcount(retire_en); retired entries' valid bits cleared. Retire is combinational from registered state, with 0-cycle latency to outputs.
- Rollback: takes effect only if rollback_en & entry rollback_idx is valid; otherwise ignored.
  - Invalidate all entries strictly younger than rollback_idx up to tail (circular range rollback_idx+1 .. tail-1).
  - Set tail = rollback_idx+1 and count = ((rollback_idx - head) mod NUM_ROB) + 1.
  - Same-cycle dispatch and retire are suppressed.
  - Same-cycle completions to surviving entries are applied.
- Count: next = count + dispatched - retired, except during rollback as above. Full (count==NUM_ROB) and empty (count==0) are distinguished by count, never by head==tail.
- Simultaneous dispatch and retire in one cycle: both apply. An entry freed this cycle is not reusable until the next cycle.
- Reset mid-operation: all in-flight entries are discarded; no retire pulses in the reset cycle.

Decomposition:
- rob_pkg holds ROB_PKT_t, ROB_ENTRY_t (packet + valid + complete) and the ROB_STATE_e enum {RUN, HALTED}. NUM_ROB, WAY, PREG_W and AREG_W defaults come from the shared defines header.
- One sub-module, rob_retire_select, is natural: a combinational prefix-AND chain producing retire_en and the retire count from per-slot ready/halt/allow vectors.

Test Plan:
- Reset, then dispatch 2/cycle for 16 cycles (NUM_ROB=32) -> dispatch_idx 0,1 ... 30,31; count=32; dispatch_ready=0 from cycle 16.
- Fill to 32, complete entries 0..3, retire_allow=11 -> retire 0,1 then 2,3; count 30 then 28; dispatch_ready returns to 1.
- Head=30, tail=4 (wrapped, count=6), rollback_idx=31 -> entries 0..3 invalid, tail=0, count=2; completion to idx 2 the next cycle is dropped.
- Rollback with rollback_idx pointing at an invalid entry -> no change to tail, count or valid bits.
- Entries 5 and 6 complete, entry 5 has halt=1 -> only retire_en[0] pulses; halted=1 next cycle; entry 6 never retires; dispatch_ready=0.
- Partial dispatch dispatch_valid=01 with one retire in the same cycle at count=10 -> count stays 10, tail advances by 1, head advances by 1.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and default geometry for the N-way reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_NUM_DEF = 32;
  localparam int unsigned ROB_WAY_DEF = 2;
  localparam int unsigned ROB_PREG_W  = 6;
  localparam int unsigned ROB_AREG_W  = 5;

  typedef struct packed {
    logic [ROB_PREG_W-1:0] t_idx;
    logic [ROB_PREG_W-1:0] told_idx;
    logic [ROB_AREG_W-1:0] dest_idx;
    logic                  halt;
    logic                  wr_mem;
    logic                  rd_mem;
  } ROB_PKT_t;

  typedef struct packed {
    ROB_PKT_t pkt;
    logic     valid;
    logic     complete;
  } ROB_ENTRY_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ROB_STATE_e;

endpackage

// File: rtl/rob_retire_select.sv
// Prefix-AND retire chain: a slot retires only if every older slot retires and none is a halt.
module rob_retire_select #(
  parameter int unsigned WAY   = 2,
  parameter int unsigned CNT_W = 6
) (
  input  logic [WAY-1:0]   slot_ready_i,
  input  logic [WAY-1:0]   slot_halt_i,
  input  logic [WAY-1:0]   slot_allow_i,
  input  logic             enable_i,
  output logic [WAY-1:0]   retire_en_o,
  output logic             retire_halt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  logic chain;

  always_comb begin
    retire_en_o   = '0;
    retire_halt_o = 1'b0;
    retire_cnt_o  = '0;
    chain         = enable_i;
    for (int k = 0; k < WAY; k++) begin
      retire_en_o[k] = chain & slot_ready_i[k] & slot_allow_i[k];
      retire_halt_o  = retire_halt_o | (retire_en_o[k] & slot_halt_i[k]);
      retire_cnt_o   = retire_cnt_o + CNT_W'(retire_en_o[k]);
      // A retiring halt closes the group so it is always the youngest retiring slot.
      chain          = retire_en_o[k] & ~slot_halt_i[k];
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: packed dispatch, out-of-order completion, in-order retire,
// single-cycle rollback to a surviving branch entry and a sticky halt state.
module rob_nway
  import rob_pkg::*;
#(
  parameter int unsigned  NUM_ROB = ROB_NUM_DEF,
  parameter int unsigned  WAY     = ROB_WAY_DEF,
  parameter int unsigned  PREG_W  = ROB_PREG_W,
  parameter int unsigned  AREG_W  = ROB_AREG_W,
  localparam int unsigned PTR_W   = $clog2(NUM_ROB)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [WAY-1:0]            dispatch_valid,
  input  ROB_PKT_t [WAY-1:0]        dispatch_pkt,
  output logic                      dispatch_ready,
  output logic [WAY-1:0][PTR_W-1:0] dispatch_idx,
  input  logic [WAY-1:0]            complete_en,
  input  logic [WAY-1:0][PTR_W-1:0] complete_idx,
  input  logic [WAY-1:0]            retire_allow,
  input  logic                      rollback_en,
  input  logic [PTR_W-1:0]          rollback_idx,
  output logic [WAY-1:0]            retire_en,
  output ROB_PKT_t [WAY-1:0]        retire_pkt,
  output logic                      halted,
  output logic [PTR_W:0]            count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  if (PREG_W != ROB_PREG_W || AREG_W != ROB_AREG_W) begin : g_bad_width
    $error("rob_nway: PREG_W/AREG_W must match the rob_pkg packet layout");
  end
  if (NUM_ROB < 4 || (NUM_ROB & (NUM_ROB - 1)) != 0 || WAY < 1 || WAY > NUM_ROB / 2)
  begin : g_bad_size
    $error("rob_nway: NUM_ROB must be a power of two >= 4 and 1 <= WAY <= NUM_ROB/2");
  end

  ROB_ENTRY_t       entries_q [NUM_ROB];
  ROB_ENTRY_t       entries_d [NUM_ROB];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  ROB_STATE_e       state_q, state_d;

  logic [WAY-1:0]   slot_ready;
  logic [WAY-1:0]   slot_halt;
  logic             retire_halt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] dispatch_cnt;
  logic             dispatch_fire;
  logic             rollback_take;
  logic [PTR_W-1:0] rollback_age;
  logic [PTR_W-1:0] entry_age;

  assign dispatch_ready = (state_q == RUN) && !rollback_en &&
                          ((CNT_W'(NUM_ROB) - count_q) >= CNT_W'(WAY));
  assign halted         = (state_q == HALTED);
  assign count          = count_q;

  always_comb begin
    slot_ready   = '0;
    slot_halt    = '0;
    retire_pkt   = '0;
    dispatch_idx = '0;
    for (int k = 0; k < WAY; k++) begin
      slot_ready[k]   = entries_q[head_q + PTR_W'(k)].valid &
                        entries_q[head_q + PTR_W'(k)].complete;
      slot_halt[k]    = entries_q[head_q + PTR_W'(k)].pkt.halt;
      retire_pkt[k]   = entries_q[head_q + PTR_W'(k)].pkt;
      dispatch_idx[k] = tail_q + PTR_W'(k);
    end
  end

  rob_retire_select #(
    .WAY   (WAY),
    .CNT_W (CNT_W)
  ) u_retire_select (
    .slot_ready_i  (slot_ready),
    .slot_halt_i   (slot_halt),
    .slot_allow_i  (retire_allow),
    .enable_i      ((state_q == RUN) & ~rollback_en & ~reset),
    .retire_en_o   (retire_en),
    .retire_halt_o (retire_halt),
    .retire_cnt_o  (retire_cnt)
  );

  always_comb begin
    entries_d     = entries_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    state_d       = state_q;
    entry_age     = '0;
    dispatch_fire = dispatch_ready & en;
    dispatch_cnt  = '0;
    for (int k = 0; k < WAY; k++) begin
      dispatch_cnt = dispatch_cnt + CNT_W'(dispatch_fire & dispatch_valid[k]);
    end
    rollback_take = rollback_en & entries_q[rollback_idx].valid;
    rollback_age  = rollback_idx - head_q;

    if (en) begin
      for (int k = 0; k < WAY; k++) begin
        if (complete_en[k] && entries_q[complete_idx[k]].valid) begin
          entries_d[complete_idx[k]].complete = 1'b1;
        end
      end
      for (int k = 0; k < WAY; k++) begin
        if (retire_en[k]) begin
          entries_d[head_q + PTR_W'(k)].valid    = 1'b0;
          entries_d[head_q + PTR_W'(k)].complete = 1'b0;
        end
        if (dispatch_fire && dispatch_valid[k]) begin
          entries_d[tail_q + PTR_W'(k)].pkt      = dispatch_pkt[k];
          entries_d[tail_q + PTR_W'(k)].valid    = 1'b1;
          entries_d[tail_q + PTR_W'(k)].complete = 1'b0;
        end
      end

      if (rollback_take) begin
        // Age relative to head orders entries; anything younger than the branch is squashed.
        for (int i = 0; i < NUM_ROB; i++) begin
          entry_age = PTR_W'(i) - head_q;
          if (entry_age > rollback_age) begin
            entries_d[i].valid    = 1'b0;
            entries_d[i].complete = 1'b0;
          end
        end
        tail_d  = rollback_idx + PTR_W'(1);
        count_d = CNT_W'(rollback_age) + CNT_W'(1);
      end else begin
        tail_d  = tail_q + PTR_W'(dispatch_cnt);
        head_d  = head_q + PTR_W'(retire_cnt);
        count_d = count_q + dispatch_cnt - retire_cnt;
      end

      if (retire_halt) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROB; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway: expected retire packets are queued as each scenario is
// set up, and a negedge monitor pops and compares them whenever retire_en pulses.
module tb_rob_nway;
  import rob_pkg::*;

  localparam int unsigned NUM_ROB = 32;
  localparam int unsigned WAY     = 2;
  localparam int unsigned PTR_W   = 5;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      en;
  logic [WAY-1:0]            dispatch_valid;
  ROB_PKT_t [WAY-1:0]        dispatch_pkt;
  logic                      dispatch_ready;
  logic [WAY-1:0][PTR_W-1:0] dispatch_idx;
  logic [WAY-1:0]            complete_en;
  logic [WAY-1:0][PTR_W-1:0] complete_idx;
  logic [WAY-1:0]            retire_allow;
  logic                      rollback_en;
  logic [PTR_W-1:0]          rollback_idx;
  logic [WAY-1:0]            retire_en;
  ROB_PKT_t [WAY-1:0]        retire_pkt;
  logic                      halted;
  logic [PTR_W:0]            count;

  int       n_checks = 0;
  int       n_fail   = 0;
  ROB_PKT_t exp_q[$];
  ROB_PKT_t mdl [NUM_ROB];
  ROB_PKT_t mon_pkt;
  int       tail_m = 0;
  int       seq_m  = 0;

  always #5 clock = ~clock;

  rob_nway #(
    .NUM_ROB (NUM_ROB),
    .WAY     (WAY),
    .PREG_W  (6),
    .AREG_W  (5)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .en             (en),
    .dispatch_valid (dispatch_valid),
    .dispatch_pkt   (dispatch_pkt),
    .dispatch_ready (dispatch_ready),
    .dispatch_idx   (dispatch_idx),
    .complete_en    (complete_en),
    .complete_idx   (complete_idx),
    .retire_allow   (retire_allow),
    .rollback_en    (rollback_en),
    .rollback_idx   (rollback_idx),
    .retire_en      (retire_en),
    .retire_pkt     (retire_pkt),
    .halted         (halted),
    .count          (count)
  );

  function automatic ROB_PKT_t mk_pkt(input int seq, input logic h);
    ROB_PKT_t p;
    p.t_idx    = 6'(seq);
    p.told_idx = 6'(seq * 5 + 1);
    p.dest_idx = 5'(seq + 3);
    p.halt     = h;
    p.wr_mem   = seq[0];
    p.rd_mem   = seq[1];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = '0;
    complete_en    = '0;
    retire_allow   = '0;
    rollback_en    = 1'b0;
  endtask

  // Drive a dispatch group; when it is expected to be accepted, record it in the model.
  task automatic disp(input logic [WAY-1:0] v, input logic [WAY-1:0] h, input bit accept);
    dispatch_valid = v;
    for (int k = 0; k < WAY; k++) begin
      dispatch_pkt[k] = mk_pkt(seq_m + k, h[k]);
      if (accept && v[k]) mdl[(tail_m + k) % NUM_ROB] = dispatch_pkt[k];
    end
    seq_m = seq_m + WAY;
    if (accept) tail_m = (tail_m + $countones(v)) % NUM_ROB;
  endtask

  task automatic push(input int idx);
    exp_q.push_back(mdl[idx]);
  endtask

  task automatic comp2(input int a, input int b);
    complete_en     = 2'b11;
    complete_idx[0] = PTR_W'(a);
    complete_idx[1] = PTR_W'(b);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      assert (((dispatch_valid + 1) & dispatch_valid) == 0)
        else $error("dispatch_valid is not packed");
    end
  end

  always @(negedge clock) begin
    if (!reset && en) begin
      for (int k = 0; k < WAY; k++) begin
        if (retire_en[k]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL retire_unexpected slot%0d: got pkt %h, required no retire", k,
                     retire_pkt[k]);
          end else begin
            mon_pkt = exp_q.pop_front();
            if (retire_pkt[k] !== mon_pkt) begin
              n_fail++;
              $display("FAIL retire_pkt slot%0d: got %h, required %h", k, retire_pkt[k],
                       mon_pkt);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    en           = 1'b1;
    dispatch_pkt = '0;
    complete_idx = '0;
    rollback_idx = '0;
    idle();
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("reset_count", 32'(count), 0);
    chk("reset_ready", 32'(dispatch_ready), 1);
    chk("reset_idx0", 32'(dispatch_idx[0]), 0);
    chk("reset_idx1", 32'(dispatch_idx[1]), 1);
    chk("reset_halted", 32'(halted), 0);
    chk("reset_retire_en", 32'(retire_en), 0);

    // Fill all 32 entries two per cycle.
    for (int c = 0; c < 16; c++) begin
      disp(2'b11, 2'b00, 1'b1);
      #1;
      chk("fill_ready", 32'(dispatch_ready), 1);
      chk("fill_idx0", 32'(dispatch_idx[0]), 2 * c);
      chk("fill_idx1", 32'(dispatch_idx[1]), 2 * c + 1);
      chk("fill_count", 32'(count), 2 * c);
      cyc();
    end
    disp(2'b11, 2'b00, 1'b0);
    #1;
    chk("full_ready", 32'(dispatch_ready), 0);
    chk("full_count", 32'(count), 32);
    cyc();
    idle();
    #1;
    chk("full_ignored_count", 32'(count), 32);

    // Complete 0..3 then retire two per cycle.
    comp2(0, 1);
    cyc();
    comp2(2, 3);
    cyc();
    idle();
    retire_allow = 2'b11;
    for (int i = 0; i < 4; i++) push(i);
    #1;
    chk("ret01_en", 32'(retire_en), 3);
    chk("ret01_count", 32'(count), 32);
    cyc();
    chk("ret23_en", 32'(retire_en), 3);
    chk("ret23_count", 32'(count), 30);
    chk("ret23_ready", 32'(dispatch_ready), 1);
    cyc();
    chk("ret_done_count", 32'(count), 28);
    chk("ret_done_en", 32'(retire_en), 0);

    // Drain 4..29 so head lands on 30.
    for (int i = 0; i < 13; i++) begin
      comp2(4 + 2 * i, 5 + 2 * i);
      retire_allow = 2'b11;
      push(4 + 2 * i);
      push(5 + 2 * i);
      cyc();
    end
    complete_en = '0;
    cyc();
    idle();
    #1;
    chk("drain_count", 32'(count), 2);
    disp(2'b11, 2'b00, 1'b1);
    #1;
    chk("wrap_idx0", 32'(dispatch_idx[0]), 0);
    cyc();
    disp(2'b11, 2'b00, 1'b1);
    #1;
    chk("wrap_idx0b", 32'(dispatch_idx[0]), 2);
    cyc();
    idle();
    #1;
    chk("wrap_count", 32'(count), 6);

    // Rollback to 31: squash 0..3, dispatch suppressed, completion to 30 survives.
    disp(2'b11, 2'b00, 1'b0);
    rollback_en     = 1'b1;
    rollback_idx    = PTR_W'(31);
    complete_en     = 2'b01;
    complete_idx[0] = PTR_W'(30);
    #1;
    chk("rb_ready", 32'(dispatch_ready), 0);
    cyc();
    idle();
    tail_m          = 0;
    complete_en     = 2'b01;
    complete_idx[0] = PTR_W'(2);
    #1;
    chk("rb_count", 32'(count), 2);
    chk("rb_tail", 32'(dispatch_idx[0]), 0);
    cyc();

    // Rollback to an invalid entry is ignored.
    idle();
    rollback_en  = 1'b1;
    rollback_idx = PTR_W'(5);
    cyc();
    idle();
    #1;
    chk("rb_inv_count", 32'(count), 2);
    chk("rb_inv_tail", 32'(dispatch_idx[0]), 0);

    complete_en     = 2'b01;
    complete_idx[0] = PTR_W'(31);
    cyc();
    idle();
    retire_allow = 2'b11;
    push(30);
    push(31);
    #1;
    chk("ret_30_31_en", 32'(retire_en), 3);
    cyc();
    chk("squashed_no_retire", 32'(retire_en), 0);
    chk("empty_count", 32'(count), 0);
    idle();

    // Ten entries 0..9, entry 5 carries halt.
    for (int c = 0; c < 5; c++) begin
      disp(2'b11, (c == 2) ? 2'b10 : 2'b00, 1'b1);
      cyc();
    end
    idle();
    complete_en     = 2'b01;
    complete_idx[0] = PTR_W'(0);
    cyc();
    idle();
    // Partial dispatch with one retire keeps count at 10.
    disp(2'b01, 2'b00, 1'b1);
    retire_allow = 2'b01;
    push(0);
    #1;
    chk("part_count_pre", 32'(count), 10);
    chk("part_retire_en", 32'(retire_en), 1);
    chk("part_idx0_pre", 32'(dispatch_idx[0]), 10);
    cyc();
    idle();
    #1;
    chk("part_count", 32'(count), 10);
    chk("part_tail", 32'(dispatch_idx[0]), 11);

    // Halt at entry 5 retires alone and freezes the buffer.
    comp2(1, 2);
    cyc();
    comp2(3, 4);
    cyc();
    comp2(5, 6);
    cyc();
    idle();
    retire_allow = 2'b11;
    for (int i = 1; i <= 5; i++) push(i);
    #1;
    chk("halt_pre_en0", 32'(retire_en), 3);
    cyc();
    chk("halt_pre_en1", 32'(retire_en), 3);
    cyc();
    chk("halt_alone", 32'(retire_en), 1);
    chk("halt_not_yet", 32'(halted), 0);
    cyc();
    chk("halted", 32'(halted), 1);
    chk("halted_retire_en", 32'(retire_en), 0);
    chk("halted_ready", 32'(dispatch_ready), 0);
    chk("halted_count", 32'(count), 5);
    disp(2'b11, 2'b00, 1'b0);
    cyc();
    chk("halted_no_disp", 32'(count), 5);
    chk("halted_retire_en2", 32'(retire_en), 0);
    idle();

    // Reset clears the halt; then reset again while entries are ready to retire.
    reset = 1'b1;
    cyc();
    reset  = 1'b0;
    tail_m = 0;
    disp(2'b11, 2'b00, 1'b1);
    cyc();
    idle();
    comp2(0, 1);
    cyc();
    idle();
    retire_allow = 2'b11;
    reset        = 1'b1;
    #1;
    chk("reset_no_retire", 32'(retire_en), 0);
    cyc();
    reset = 1'b0;
    idle();
    #1;
    chk("rst2_count", 32'(count), 0);
    chk("rst2_halted", 32'(halted), 0);
    chk("rst2_ready", 32'(dispatch_ready), 1);
    chk("rst2_idx1", 32'(dispatch_idx[1]), 1);

    // Global stall: dispatch request has no effect.
    en = 1'b0;
    disp(2'b11, 2'b00, 1'b0);
    #1;
    chk("stall_ready", 32'(dispatch_ready), 1);
    cyc();
    idle();
    en = 1'b1;
    #1;
    chk("stall_count", 32'(count), 0);
    chk("stall_tail", 32'(dispatch_idx[0]), 0);

    cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
